// File: rtl/noc_flit_to_axis_depacketizer.sv
// noc_flit_to_axis_depacketizer: rebuilds AXI4-Stream packets from NoC flits behind a 2-entry skid buffer
module noc_flit_to_axis_depacketizer #(
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4,
    parameter int DestWidth = 8,
    parameter int CntWidth  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [DataWidth+1:0]      flit_i,
    input  logic                      flit_valid_i,
    output logic                      flit_ready_o,
    output logic [DataWidth-1:0]      m_axis_tdata_o,
    output logic [IdWidth-1:0]        m_axis_tid_o,
    output logic [DestWidth-1:0]      m_axis_tdest_o,
    output logic                      m_axis_tlast_o,
    output logic                      m_axis_tvalid_o,
    input  logic                      m_axis_tready_i,
    output logic [CntWidth-1:0]       pkt_count_o,
    output logic [CntWidth-1:0]       err_count_o,
    output logic                      error_o
);
    localparam int FlitWidth = DataWidth + 2;

    if (IdWidth + DestWidth > DataWidth) begin : g_width_chk
        $error("IdWidth + DestWidth must not exceed DataWidth");
    end

    typedef enum logic {IDLE, PAYLOAD} state_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   tid;
        logic [DestWidth-1:0] tdest;
        logic                 last;
    } beat_t;

    state_t               state_q, state_d;
    beat_t                main_q, skid_q, beat;
    logic                 main_v, skid_v, rdy_q, err_q;
    logic [IdWidth-1:0]   tid_q;
    logic [DestWidth-1:0] tdest_q;
    logic [CntWidth-1:0]  pkt_q, errc_q;
    logic [1:0]           ftype;
    logic                 accept, push, pop, drop, latch;

    assign ftype        = flit_i[FlitWidth-1 -: 2];
    assign flit_ready_o = rdy_q & ~skid_v;
    assign accept       = flit_valid_i & flit_ready_o;
    assign pop          = main_v & m_axis_tready_i;
    assign beat         = {flit_i[DataWidth-1:0], tid_q, tdest_q, ftype == 2'b10};

    // packet framing: headers open a packet, body/tail produce beats, anything unexpected is dropped
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        drop    = 1'b0;
        latch   = 1'b0;
        if (accept) begin
            if (state_q == IDLE) begin
                latch   = ftype == 2'b00;
                drop    = ftype != 2'b00;
                state_d = ftype == 2'b00 ? PAYLOAD : IDLE;
            end else begin
                push    = ftype[0] ^ ftype[1];
                drop    = ~(ftype[0] ^ ftype[1]);
                state_d = ftype == 2'b10 ? IDLE : PAYLOAD;
            end
        end
    end

    // state, header latches, counters and the main/skid beat buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            main_q  <= '0;
            skid_q  <= '0;
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            tid_q   <= '0;
            tdest_q <= '0;
            pkt_q   <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            err_q   <= drop;
            if (latch) begin
                tid_q   <= flit_i[DestWidth+IdWidth-1:DestWidth];
                tdest_q <= flit_i[DestWidth-1:0];
            end
            if (drop && !(&errc_q)) errc_q <= errc_q + CntWidth'(1);
            if (pop && main_q.last) pkt_q <= pkt_q + CntWidth'(1);
            if (pop) begin
                if (skid_v) begin
                    main_q <= skid_q;
                    skid_v <= 1'b0;
                end else if (push) begin
                    main_q <= beat;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (push) begin
                if (!main_v) begin
                    main_q <= beat;
                    main_v <= 1'b1;
                end else begin
                    skid_q <= beat;
                    skid_v <= 1'b1;
                end
            end
        end
    end

    assign m_axis_tdata_o  = main_q.data;
    assign m_axis_tid_o    = main_q.tid;
    assign m_axis_tdest_o  = main_q.tdest;
    assign m_axis_tlast_o  = main_q.last;
    assign m_axis_tvalid_o = main_v;
    assign pkt_count_o     = pkt_q;
    assign err_count_o     = errc_q;
    assign error_o         = err_q;
endmodule

// File: tb/tb_noc_flit_to_axis_depacketizer.sv
// tb_noc_flit_to_axis_depacketizer: directed and random packets checked against a queue-based packet model
module tb_noc_flit_to_axis_depacketizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [65:0] flit = '0;
    logic        flit_valid = 1'b0;
    logic        flit_ready;
    logic [63:0] tdata;
    logic [3:0]  tid;
    logic [7:0]  tdest;
    logic        tlast, tvalid;
    logic        tready = 1'b1;
    logic [15:0] pkt_count, err_count;
    logic        error;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit rand_rdy = 1'b0;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  id;
        logic [7:0]  dest;
        logic        last;
    } beat_t;

    beat_t       q[$];
    beat_t       log_q[$];
    bit          m_in_pkt, m_rdy, m_errp;
    logic [3:0]  m_tid;
    logic [7:0]  m_dest;
    logic [15:0] m_pkt, m_err;

    noc_flit_to_axis_depacketizer dut (
        .clk_i(clk), .rst_ni(rst_n), .flit_i(flit), .flit_valid_i(flit_valid),
        .flit_ready_o(flit_ready), .m_axis_tdata_o(tdata), .m_axis_tid_o(tid),
        .m_axis_tdest_o(tdest), .m_axis_tlast_o(tlast), .m_axis_tvalid_o(tvalid),
        .m_axis_tready_i(tready), .pkt_count_o(pkt_count), .err_count_o(err_count),
        .error_o(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rand_rdy) tready = $urandom_range(0, 3) != 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: packet rules over queues, then a full output comparison every cycle
    initial begin : cmp
        bit    exp_rdy, pop, acc;
        beat_t b;
        logic [1:0] t;
        forever begin
            @(posedge clk);
            m_errp = 1'b0;
            if (!rst_n) begin
                q.delete();
                m_in_pkt = 0; m_rdy = 0; m_tid = '0; m_dest = '0; m_pkt = '0; m_err = '0;
            end else begin
                exp_rdy = m_rdy && q.size() < 2;
                pop = q.size() > 0 && tready;
                t = flit[65:64];
                acc = flit_valid && exp_rdy;
                if (pop) begin
                    b = q.pop_front();
                    log_q.push_back(b);
                    if (b.last) m_pkt = m_pkt + 1;
                end
                if (acc) begin
                    if (!m_in_pkt && t == 2'b00) begin
                        m_in_pkt = 1; m_tid = flit[11:8]; m_dest = flit[7:0];
                    end else if (m_in_pkt && (t == 2'b01 || t == 2'b10)) begin
                        q.push_back('{d: flit[63:0], id: m_tid, dest: m_dest, last: t == 2'b10});
                        if (t == 2'b10) m_in_pkt = 0;
                    end else begin
                        m_errp = 1'b1;
                        if (m_err != 16'hFFFF) m_err = m_err + 1;
                    end
                end
                m_rdy = 1;
            end
            #1;
            chk("flit_ready", flit_ready, m_rdy && q.size() < 2);
            chk("tvalid", tvalid, q.size() > 0);
            if (q.size() > 0) begin
                chk("tdata", tdata, q[0].d);
                chk("tid", tid, q[0].id);
                chk("tdest", tdest, q[0].dest);
                chk("tlast", tlast, q[0].last);
            end
            chk("pkt_count", pkt_count, m_pkt);
            chk("err_count", err_count, m_err);
            chk("error_o", error, m_errp);
            if (error) pulses++;
            if (!rst_n) chk("rst_outputs", {tdata, tid, tdest, tlast, error}, '0);
        end
    end

    task automatic send(input logic [1:0] t, input logic [63:0] p);
        bit r;
        flit = {t, p};
        flit_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            r = flit_ready;
            @(posedge clk);
            #1;
            if (r) break;
            if (n > 2000) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        flit_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        log_q.delete();
        pulses = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 5000; n++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) break;
        end
        chk("drain_left", q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total, len;
        repeat (2) @(negedge clk);
        chk("ready_in_reset", flit_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: simple packet at full rate
        send(2'b00, 64'h312);
        send(2'b01, 64'hA);
        send(2'b01, 64'hB);
        send(2'b10, 64'hC);
        drain();
        chk("t1_beats", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_b0", {log_q[0].d, log_q[0].id, log_q[0].dest, log_q[0].last}, {64'hA, 4'd3, 8'h12, 1'b0});
            chk("t1_b1", {log_q[1].d, log_q[1].last}, {64'hB, 1'b0});
            chk("t1_b2", {log_q[2].d, log_q[2].last}, {64'hC, 1'b1});
        end
        chk("t1_pkt", pkt_count, 1);

        // 2: stalled downstream fills the skid and back-pressures
        do_reset();
        tready = 1'b0;
        fork
            begin
                send(2'b00, 64'h312);
                send(2'b01, 64'hA);
                send(2'b01, 64'hB);
                send(2'b10, 64'hC);
            end
            begin
                repeat (6) @(negedge clk);
                chk("t2_ready_low", flit_ready, 0);
                chk("t2_hold", {tvalid, tdata}, {1'b1, 64'hA});
                tready = 1'b1;
            end
        join
        drain();
        chk("t2_beats", log_q.size(), 3);
        if (log_q.size() == 3)
            chk("t2_order", {log_q[0].d[3:0], log_q[1].d[3:0], log_q[2].d[3:0]}, 12'hABC);

        // 3: payload flits outside a packet are dropped
        do_reset();
        send(2'b01, 64'h5);
        send(2'b11, 64'h0);
        drain();
        chk("t3_err", err_count, 2);
        chk("t3_pulses", pulses, 2);
        chk("t3_beats", log_q.size(), 0);

        // 4: header inside a packet is dropped and the old tid kept
        do_reset();
        send(2'b00, 64'h100);
        send(2'b01, 64'h1);
        send(2'b00, 64'h700);
        send(2'b10, 64'h2);
        drain();
        chk("t4_beats", log_q.size(), 2);
        if (log_q.size() == 2)
            chk("t4_vals", {log_q[0].d[7:0], log_q[0].id, log_q[1].d[7:0], log_q[1].id, log_q[1].last},
                {8'h1, 4'd1, 8'h2, 4'd1, 1'b1});
        chk("t4_err", err_count, 1);
        chk("t4_pkt", pkt_count, 1);

        // 6: reset in the middle of a packet
        do_reset();
        tready = 1'b0;
        send(2'b00, 64'h2AB);
        send(2'b01, 64'h9);
        do_reset();
        chk("t6_no_beat", log_q.size(), 0);
        chk("t6_idle", {tvalid, pkt_count}, 0);
        tready = 1'b1;
        send(2'b00, 64'h5CD);
        send(2'b01, 64'h11);
        send(2'b10, 64'h22);
        drain();
        chk("t6_pkt", pkt_count, 1);
        chk("t6_beats", log_q.size(), 2);
        if (log_q.size() == 2)
            chk("t6_vals", {log_q[0].id, log_q[0].dest, log_q[1].d[7:0]}, {4'd5, 8'hCD, 8'h22});

        // 5: random packets with random gaps and back-pressure
        do_reset();
        rand_rdy = 1'b1;
        total = 0;
        for (int p = 0; p < 1000; p++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(2'b00, {$urandom, $urandom});
            len = $urandom_range(1, 16);
            total += len;
            for (int i = 1; i < len; i++) send(2'b01, {$urandom, $urandom});
            send(2'b10, {$urandom, $urandom});
        end
        @(posedge clk);
        rand_rdy = 1'b0;
        tready = 1'b1;
        drain();
        chk("t5_pkt", pkt_count, 1000);
        chk("t5_err", err_count, 0);
        chk("t5_beats", log_q.size(), total);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
